// File: rtl/alu_apb_regif.sv
// APB register front-end for the ALU core: operand/opcode registers, a one-shot
// issue FSM with valid/ready handshake and timeout, and result/flag read-back.
module alu_apb_regif #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_res_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [3:0]        alu_flags,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    logic              irq_en;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] opa, opb, res;
    logic [3:0]        flags;
    logic              stat_done, stat_err;

    logic [2:0]        idx;
    logic              mapped, setup, access, busy;
    logic              req_err, wr_sel, start_acc;
    logic              set_done, set_err, latch_res;
    logic [31:0]       rd_data;
    logic              unused_ok;

    assign idx       = paddr[4:2];
    assign mapped    = (paddr[ADDR_W-1:5] == '0) && (idx <= 3'd4);
    assign setup     = psel & ~penable;
    assign access    = psel & penable;
    assign busy      = (state != S_IDLE);
    assign unused_ok = ^{paddr[1:0], pwdata};

    // CTRL writes while busy are rejected only if they would start or change the opcode,
    // so irq_en stays writable during an operation.
    always_comb begin
        req_err = 1'b0;
        if (!mapped) begin
            req_err = 1'b1;
        end else if (pwrite) begin
            case (idx)
                3'd0:    req_err = busy && (pwdata[0] || (pwdata[7:4] != opcode));
                3'd1,
                3'd2:    req_err = busy;
                3'd3:    req_err = 1'b1;
                default: req_err = 1'b0;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            3'd0:    rd_data = {24'h0, opcode, 2'b00, irq_en, 1'b0};
            3'd1:    rd_data = 32'(opa);
            3'd2:    rd_data = 32'(opb);
            3'd3:    rd_data = 32'(res);
            3'd4:    rd_data = {24'h0, flags, 1'b0, busy, stat_err, stat_done};
            default: rd_data = '0;
        endcase
    end

    // Response is captured in SETUP and presented for exactly the following ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prdata  <= '0;
            pslverr <= 1'b0;
        end else if (setup) begin
            prdata  <= (!pwrite && mapped) ? rd_data : '0;
            pslverr <= req_err;
        end else begin
            prdata  <= '0;
            pslverr <= 1'b0;
        end
    end

    assign wr_sel    = access && pwrite && !pslverr && mapped;
    assign start_acc = wr_sel && (idx == 3'd0) && pwdata[0] && (state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en    <= 1'b0;
            opcode    <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            flags     <= '0;
            stat_done <= 1'b0;
            stat_err  <= 1'b0;
        end else begin
            if (wr_sel) begin
                case (idx)
                    3'd0: begin
                        irq_en <= pwdata[1];
                        opcode <= pwdata[7:4];
                    end
                    3'd1:    opa <= pwdata[DATA_W-1:0];
                    3'd2:    opb <= pwdata[DATA_W-1:0];
                    default: ;
                endcase
            end
            if (latch_res) begin
                res   <= alu_res;
                flags <= alu_flags;
            end
            // Hardware set takes priority over a coincident W1C clear.
            if (set_done)
                stat_done <= 1'b1;
            else if (wr_sel && (idx == 3'd4) && pwdata[0])
                stat_done <= 1'b0;
            if (set_err)
                stat_err <= 1'b1;
            else if (wr_sel && (idx == 3'd4) && pwdata[1])
                stat_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        set_done  = 1'b0;
        set_err   = 1'b0;
        latch_res = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    state_nx = S_ISSUE;
                    cnt_nx   = '0;
                end
            end
            S_ISSUE: begin
                cnt_nx = cnt + 1'b1;
                if (cnt_nx == CNT_W'(TIMEOUT)) begin
                    state_nx = S_IDLE;
                    set_err  = 1'b1;
                end else if (alu_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt + 1'b1;
                if (alu_res_valid) begin
                    state_nx  = S_IDLE;
                    latch_res = 1'b1;
                    set_done  = 1'b1;
                end else if (cnt_nx == CNT_W'(TIMEOUT)) begin
                    state_nx = S_IDLE;
                    set_err  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign pready    = 1'b1;
    assign alu_valid = (state == S_ISSUE);
    assign alu_op    = opcode;
    assign alu_a     = opa;
    assign alu_b     = opb;
    assign irq       = stat_done & irq_en;

endmodule

// File: tb/tb_alu_apb_regif.sv
// Directed self-checking bench for alu_apb_regif: APB accesses, ALU handshake,
// timeout abort, error responses and asynchronous reset behaviour.
module tb_alu_apb_regif;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_res_valid = 1'b0;
    logic [31:0] alu_res = '0;
    logic [3:0]  alu_flags = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_apb_regif #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .alu_res_valid(alu_res_valid), .alu_res(alu_res),
        .alu_flags(alu_flags), .irq(irq)
    );

    // Returns #1 after the commit edge, i.e. in cycle N+1 of an ACCESS in cycle N.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        d = prdata;
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        #2;
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata got %h exp 0", prdata); end
        checks++; if ({pready, pslverr, alu_valid, irq} !== 4'b1000) begin errors++; $display("FAIL rst_ctl got %b exp 1000", {pready, pslverr, alu_valid, irq}); end
        @(posedge clk); #1; reset = 1'b0;
        apb_read(32'h10, d, e);
        checks++; if ({e, d} !== 33'h0) begin errors++; $display("FAIL rst_stat got %b/%h exp 0/0", e, d); end
        apb_read(32'h00, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", d); end
    endtask

    task automatic test_basic_op();
        logic [31:0] d;
        logic e;
        apb_write(32'h04, 32'h9841_C0D6, e);
        apb_write(32'h08, 32'h0000_0001, e);
        apb_read(32'h04, d, e);
        checks++; if (d !== 32'h9841_C0D6) begin errors++; $display("FAIL opa_rd got %h exp 9841c0d6", d); end
        apb_write(32'h00, 32'h13, e);
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL issue_latency got %b exp 1", alu_valid); end
        checks++; if ({alu_op, alu_a, alu_b} !== {4'h1, 32'h9841_C0D6, 32'h1}) begin errors++; $display("FAIL issue_bus got %h/%h/%h exp 1/9841c0d6/1", alu_op, alu_a, alu_b); end
        alu_ready = 1'b1;
        @(posedge clk); #1;
        alu_ready = 1'b0;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got %b exp 0", alu_valid); end
        repeat (3) @(posedge clk);
        #1;
        alu_res = 32'h9841_C0D7; alu_flags = 4'b1000; alu_res_valid = 1'b1;
        @(posedge clk); #1;
        alu_res_valid = 1'b0;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_done got %b exp 1", irq); end
        apb_read(32'h0C, d, e);
        checks++; if (d !== 32'h9841_C0D7) begin errors++; $display("FAIL res_rd got %h exp 9841c0d7", d); end
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h81) begin errors++; $display("FAIL stat_done got %h exp 81", d); end
        apb_write(32'h10, 32'h1, e);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h80) begin errors++; $display("FAIL stat_w1c got %h exp 80", d); end
    endtask

    task automatic test_busy_write();
        logic [31:0] d;
        logic e;
        apb_write(32'h04, 32'h1111_1111, e);
        apb_write(32'h00, 32'h21, e);
        alu_ready = 1'b1;
        @(posedge clk); #1;
        alu_ready = 1'b0;
        apb_write(32'h04, 32'h0000_DEAD, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_opa_err got %b exp 1", e); end
        checks++; if (alu_a !== 32'h1111_1111) begin errors++; $display("FAIL busy_opa_keep got %h exp 11111111", alu_a); end
        apb_write(32'h00, 32'h21, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL busy_start_err got %b exp 1", e); end
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h84) begin errors++; $display("FAIL busy_stat got %h exp 84", d); end
        alu_res = 32'h2222_2222; alu_flags = 4'b0000; alu_res_valid = 1'b1;
        @(posedge clk); #1;
        alu_res_valid = 1'b0;
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL busy_done got %h exp 01", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq); end
        apb_read(32'h0C, d, e);
        checks++; if (d !== 32'h2222_2222) begin errors++; $display("FAIL busy_res got %h exp 22222222", d); end
        apb_write(32'h10, 32'h1, e);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic e;
        int n;
        apb_write(32'h00, 32'h33, e);
        n = 0;
        while (alu_valid === 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != 255) begin errors++; $display("FAIL timeout_len got %0d exp 255", n); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timeout_irq got %b exp 0", irq); end
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h02) begin errors++; $display("FAIL timeout_stat got %h exp 02", d); end
        apb_write(32'h10, 32'h2, e);
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL err_clr got %h exp 00", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic e;
        apb_read(32'h14, d, e);
        checks++; if ({e, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rd_14 got %b/%h exp 1/0", e, d); end
        apb_read(32'h40, d, e);
        checks++; if ({e, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rd_40 got %b/%h exp 1/0", e, d); end
        apb_read(32'h8000_000C, d, e);
        checks++; if ({e, d} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rd_hi got %b/%h exp 1/0", e, d); end
        apb_write(32'h0C, 32'h5, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_res_err got %b exp 1", e); end
        apb_read(32'h0F, d, e);
        checks++; if ({e, d} !== {1'b0, 32'h2222_2222}) begin errors++; $display("FAIL res_lowbits got %b/%h exp 0/22222222", e, d); end
        @(posedge clk); #1;
        checks++; if ({pslverr, prdata} !== 33'h0) begin errors++; $display("FAIL idle_resp got %b/%h exp 0/0", pslverr, prdata); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        logic e;
        apb_write(32'h00, 32'h01, e);
        alu_ready = 1'b1;
        @(posedge clk); #1;
        alu_ready = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        alu_res = 32'h77; alu_flags = 4'b0100; alu_res_valid = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; alu_res_valid = 1'b0;
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h41) begin errors++; $display("FAIL w1c_set_wins got %h exp 41", d); end
        apb_write(32'h10, 32'h1, e);
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        logic e;
        apb_write(32'h00, 32'h51, e);
        #2; reset = 1'b1; #1;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", alu_valid); end
        #2; reset = 1'b0;
        apb_write(32'h00, 32'h51, e);
        alu_ready = 1'b1;
        @(posedge clk); #1;
        alu_ready = 1'b0;
        #2; reset = 1'b1;
        alu_res = 32'hABCD; alu_res_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        alu_res_valid = 1'b0;
        apb_read(32'h0C, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_res got %h exp 0", d); end
        apb_read(32'h10, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_stat_mid got %h exp 0", d); end
        checks++; if ({alu_valid, irq} !== 2'b00) begin errors++; $display("FAIL rst_out got %b exp 00", {alu_valid, irq}); end
    endtask

    initial begin
        test_reset();
        test_basic_op();
        test_busy_write();
        test_timeout();
        test_unmapped();
        test_w1c_collision();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
